// File: rtl/ssaes444_pkg.sv
// Shared constants, the 4-bit S-box and the scheduler FSM encoding for the
// small-scale AES 4x4x4 SubWord scheduler.
package ssaes444_pkg;

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned STATE_W  = 64;
    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned NCOLS    = 4;
    localparam int unsigned COL_W    = 2;
    localparam int unsigned SBOX_N   = 16;

    // S-box table, indexed by the input nibble.
    localparam logic [NIBBLE_W-1:0] SBOX [SBOX_N] = '{
        4'h6, 4'hB, 4'h5, 4'h4, 4'h2, 4'hE, 4'h7, 4'hA,
        4'h9, 4'hD, 4'hF, 4'hC, 4'h3, 4'h1, 4'h0, 4'h8
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_e;

    // Single-nibble substitution.
    function automatic logic [NIBBLE_W-1:0] sbox(input logic [NIBBLE_W-1:0] x);
        return SBOX[x];
    endfunction

endpackage

// File: rtl/ssaes444_subword_sched_subword.sv
// Shared SubWord: four parallel 4-bit S-boxes over one 16-bit word.
//   word   in  16  operand word
//   result out 16  substituted word (combinational)
module ssaes444_subword_sched_subword
    import ssaes444_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] result
);

    always_comb begin
        result = '0;
        for (int unsigned i = 0; i < WORD_W / NIBBLE_W; i++) begin
            result[i*NIBBLE_W +: NIBBLE_W] = sbox(word[i*NIBBLE_W +: NIBBLE_W]);
        end
    end

endmodule

// File: rtl/ssaes444_subword_sched.sv
// Time-multiplexes one SubWord between key-schedule word requests and the
// four columns of a datapath SubBytes job.
//   clk, rst_n            clock, async active-low reset
//   ks_req/ks_word        key-schedule request and operand
//   ks_gnt                combinational grant (ks_word consumed this cycle)
//   ks_ack/ks_result      registered grant and substituted word
//   dp_start/dp_state     job start pulse and 64-bit state
//   dp_busy/dp_done       job in progress / one-cycle completion pulse
//   dp_result             substituted state, updated on entering DONE
module ssaes444_subword_sched
    import ssaes444_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ks_req,
    input  logic [WORD_W-1:0]  ks_word,
    output logic               ks_gnt,
    output logic               ks_ack,
    output logic [WORD_W-1:0]  ks_result,
    input  logic               dp_start,
    input  logic [STATE_W-1:0] dp_state,
    output logic               dp_busy,
    output logic               dp_done,
    output logic [STATE_W-1:0] dp_result
);

    sched_state_e       fsm_q, fsm_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [COL_W-1:0]   cnt_q, cnt_d;
    logic               last_ks_q;

    logic [STATE_W-1:0] dp_result_d;
    logic [WORD_W-1:0]  ks_result_d;
    logic               dp_busy_d, dp_done_d;

    logic [5:0]         col_idx;
    logic [WORD_W-1:0]  col_word;
    logic [WORD_W-1:0]  sw_in, sw_out;

    assign col_idx  = {cnt_q, 4'b0000};
    assign col_word = state_q[col_idx +: WORD_W];

    // Arbiter: in RUN the fair policy yields to DP after every KS grant.
    always_comb begin
        ks_gnt = ks_req;
        if (fsm_q == ST_RUN) begin
            ks_gnt = ks_req & (~FAIR | ~last_ks_q);
        end
    end

    assign sw_in = ks_gnt ? ks_word : col_word;

    ssaes444_subword_sched_subword u_subword (
        .word   (sw_in),
        .result (sw_out)
    );

    // Next-state and next-output logic.
    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        dp_result_d = dp_result;
        ks_result_d = ks_gnt ? sw_out : ks_result;

        case (fsm_q)
            ST_IDLE: begin
                if (dp_start) begin
                    fsm_d   = ST_RUN;
                    state_d = dp_state;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (!ks_gnt) begin
                    state_d[col_idx +: WORD_W] = sw_out;
                    cnt_d = cnt_q + COL_W'(1);
                    if (cnt_q == COL_W'(NCOLS - 1)) begin
                        fsm_d       = ST_DONE;
                        dp_result_d = state_d;
                    end
                end
            end
            ST_DONE: begin
                if (dp_start) begin
                    fsm_d   = ST_RUN;
                    state_d = dp_state;
                    cnt_d   = '0;
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase

        dp_busy_d = (fsm_d == ST_RUN);
        dp_done_d = (fsm_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= ST_IDLE;
            state_q   <= '0;
            cnt_q     <= '0;
            last_ks_q <= 1'b0;
            ks_ack    <= 1'b0;
            ks_result <= '0;
            dp_busy   <= 1'b0;
            dp_done   <= 1'b0;
            dp_result <= '0;
        end else begin
            fsm_q     <= fsm_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_ks_q <= ks_gnt;
            ks_ack    <= ks_gnt;
            ks_result <= ks_result_d;
            dp_busy   <= dp_busy_d;
            dp_done   <= dp_done_d;
            dp_result <= dp_result_d;
        end
    end

endmodule

// File: doc/ssaes444_subword_sched.md
# ssaes444_subword_sched

Time-multiplexes one 16-bit SubWord (four 4-bit S-boxes) between the small-scale AES 4×4×4 key schedule and the round datapath's SubBytes step. The datapath submits a 64-bit state as a job; the scheduler substitutes its four 16-bit columns one per cycle. It interleaves single-word key-schedule requests using a fixed-priority or alternating policy. The block sits between the round controller, the key-expansion unit and the single shared SubWord instance.

## Interface
Parameters:
- FAIR, 1: 1 = alternate KS/DP under contention; 0 = strict key-schedule priority.

Ports:
- clk  in  1  single clock; all flops rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- ks_req  in  1  key-schedule word request, sampled every cycle.
- ks_word  in  16  word to substitute; valid while ks_req=1.
- ks_gnt  out  1  combinational; ks_word consumed this cycle.
- ks_ack  out  1  registered ks_gnt; ks_result valid this cycle.
- ks_result  out  16  SubWord(ks_word of grant cycle); holds until next ack.
- dp_start  in  1  job start pulse; accepted only when dp_busy=0.
- dp_state  in  64  state to substitute; column c = bits [16c+15:16c].
- dp_busy  out  1  job in progress.
- dp_done  out  1  one-cycle pulse; dp_result valid.
- dp_result  out  64  substituted state; holds until next accepted dp_start.

## Operation
- FSM states:
  - IDLE: wait for dp_start.
  - RUN: substitute columns c=0..3 in ascending order; 2-bit column counter.
  - DONE: single cycle; dp_done=1, dp_busy=0.
- Transitions:
  - IDLE→RUN on dp_start; load the state register from dp_state and clear the counter.
  - RUN→DONE when column 3 is written.
  - DONE→RUN on dp_start, else DONE→IDLE.
- One SubWord evaluation per cycle. The operand mux selects ks_word when ks_gnt=1, else the current column.
- A DP column is written back in place at the edge ending its cycle, and the counter increments.
- Arbitration in RUN with ks_req=1:
  - FAIR=0: KS always wins.
  - FAIR=1: KS wins unless last_ks=1 (KS granted in the previous cycle), in which case DP wins.
  - last_ks is updated every cycle to ks_gnt.
- In IDLE/DONE, ks_gnt=ks_req. A dp_start accepted in the same cycle does not conflict: loading the state register does not use SubWord.
- dp_start while dp_busy=1 is ignored, with no effect on state or outputs.
- Reset value of every output is 0. Reset also sets FSM=IDLE, last_ks=0, counter=0 and clears the state register.
- Reset mid-job aborts the job: no dp_done, no ks_ack for an in-flight grant.

## Timing
- dp_start sampled in cycle 0 with no KS contention: columns substituted in cycles 1–4, dp_done in cycle 5. dp_busy=1 in cycles 1–4.
- Each KS grant during RUN adds exactly one cycle to DP latency.
- FAIR=1 worst-case DP latency: 9 cycles. Worst-case KS wait: 1 cycle.
- KS latency: grant in cycle N gives ks_ack/ks_result in cycle N+1.
- ks_req held high produces back-to-back grants. The requester must change ks_word on the cycle after each ks_gnt.
- dp_result updates on the edge entering DONE.

## Structure
- Package ssaes444_pkg:
  - WORD_W=16, STATE_W=64, NIBBLE_W=4, NCOLS=4.
  - S-box constant table {6,B,5,4,2,E,7,A,9,D,F,C,3,1,0,8}.
  - FSM state enum.
- One sub-module: the existing SubWord, instantiated once, fed by the operand mux.
- Arbiter, FSM and registers live in this module.

## Test plan
- FAIR=1, no ks_req; dp_start with dp_state=64'h0123_4567_89AB_CDEF in cycle 0 → dp_done in cycle 5, dp_result=64'h6B54_2E7A_9DFC_3108.
- Idle; ks_req=1 for one cycle with ks_word=16'h0000 → ks_gnt that cycle, ks_ack next cycle, ks_result=16'h6666.
- FAIR=1; dp_start in cycle 0, ks_req held from cycle 1 (ks_word=16'hFEDC) →
  - ks_gnt in cycles 1,3,5,7; columns in cycles 2,4,6,8.
  - dp_done in cycle 9; every ks_result=16'h8013.
- FAIR=0; same job, ks_req held in cycles 1–6 → columns in cycles 7–10, dp_done in cycle 11.
- dp_start with 64'hFFFF_FFFF_FFFF_FFFF, second dp_start in cycle 2 with 64'h0 → second ignored; dp_result=64'h8888_8888_8888_8888.
- rst_n low in cycle 3 of a job → all outputs 0 asynchronously. No dp_done after release. A new job after release completes normally in 5 cycles.
